// File: rtl/conv_psum_accum.sv
// conv_psum_accum: partial-sum buffer closing the 4x4 MAC accumulation loop
// across input channels. Non-final channels park the MAC result per output
// pixel and feed it back as last_result; the final channel is requantised
// (ReLU, round, shift, saturate) into an 8-bit activation behind a
// valid/ready output register.
module conv_psum_accum #(
    parameter int lenOfInput  = 8,
    parameter int lenOfOutput = 25,
    parameter int NUM_PIX     = 16,
    parameter int NUM_CH      = 4,
    parameter int SHIFT       = 8,
    localparam int PW = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1,
    localparam int CW = (NUM_CH  > 1) ? $clog2(NUM_CH)  : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [lenOfOutput-1:0] in_result,
    output logic signed [lenOfOutput-1:0] last_result,
    output logic        [PW-1:0]          pix_idx,
    output logic        [CW-1:0]          ch_idx,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [lenOfInput-1:0]  out_data,
    output logic                          tile_done,
    output logic                          sat_flag
);

    localparam logic [PW-1:0] PIX_LAST = PW'(NUM_PIX - 1);
    localparam logic [CW-1:0] CH_LAST  = CW'(NUM_CH - 1);
    localparam logic [PW-1:0] PIX_ONE  = PW'(1);
    localparam logic [CW-1:0] CH_ONE   = CW'(1);

    // Rounding constant and positive clamp, both at the widened sum width
    // so the +half step can never wrap.
    localparam logic [lenOfOutput:0] RND_HALF =
        {{lenOfOutput{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic [lenOfOutput:0] POS_MAX_W =
        ({{lenOfOutput{1'b0}}, 1'b1} << (lenOfInput - 1)) - {{lenOfOutput{1'b0}}, 1'b1};
    localparam logic [lenOfInput-1:0] POS_MAX = {1'b0, {(lenOfInput-1){1'b1}}};

    // Requantise one final-channel sum; returns {saturated, activation}.
    function automatic logic [lenOfInput:0] requant(
        input logic signed [lenOfOutput-1:0] v
    );
        logic [lenOfOutput:0] r;
        logic [lenOfOutput:0] sh;
        logic [lenOfInput:0]  res;
        if (v[lenOfOutput-1]) begin
            r = {(lenOfOutput+1){1'b0}};
        end else begin
            r = {1'b0, v};
        end
        r  = r + RND_HALF;
        sh = r >> SHIFT;
        if (sh > POS_MAX_W) begin
            res = {1'b1, POS_MAX};
        end else begin
            res = {1'b0, sh[lenOfInput-1:0]};
        end
        return res;
    endfunction

    // Architectural state
    logic [PW-1:0]                 pix_cnt_q, pix_cnt_d;
    logic [CW-1:0]                 ch_cnt_q,  ch_cnt_d;
    logic                          out_valid_q, out_valid_d;
    logic signed [lenOfInput-1:0]  out_data_q,  out_data_d;
    logic                          tile_done_q, tile_done_d;
    logic                          sat_flag_q,  sat_flag_d;
    logic signed [lenOfOutput-1:0] psum_buf_q [NUM_PIX];

    // Datapath helpers
    logic                          last_ch_s;
    logic                          pix_wrap_s;
    logic                          in_ready_s;
    logic                          accept_s;
    logic                          buf_we_s;
    logic [lenOfInput:0]           rq_s;

    // Handshake and decode of the current tile position.
    always_comb begin
        last_ch_s  = (ch_cnt_q == CH_LAST);
        pix_wrap_s = (pix_cnt_q == PIX_LAST);
        if (last_ch_s) begin
            in_ready_s = !out_valid_q || out_ready;
        end else begin
            in_ready_s = 1'b1;
        end
        accept_s = in_valid && in_ready_s;
        buf_we_s = accept_s && !last_ch_s && !clr && !rst;
        rq_s     = requant(in_result);
    end

    // Next-state: counters, output register, tile pulse and sticky saturation.
    always_comb begin
        pix_cnt_d   = pix_cnt_q;
        ch_cnt_d    = ch_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        tile_done_d = 1'b0;
        sat_flag_d  = sat_flag_q;
        if (clr) begin
            pix_cnt_d   = {PW{1'b0}};
            ch_cnt_d    = {CW{1'b0}};
            out_valid_d = 1'b0;
            out_data_d  = {lenOfInput{1'b0}};
            sat_flag_d  = 1'b0;
        end else begin
            // Draining frees the register; a same-cycle load below refills it.
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
            if (accept_s) begin
                if (pix_wrap_s) begin
                    pix_cnt_d = {PW{1'b0}};
                    if (last_ch_s) begin
                        ch_cnt_d = {CW{1'b0}};
                    end else begin
                        ch_cnt_d = ch_cnt_q + CH_ONE;
                    end
                end else begin
                    pix_cnt_d = pix_cnt_q + PIX_ONE;
                    ch_cnt_d  = ch_cnt_q;
                end
                if (last_ch_s) begin
                    out_valid_d = 1'b1;
                    out_data_d  = rq_s[lenOfInput-1:0];
                    sat_flag_d  = sat_flag_q | rq_s[lenOfInput];
                    tile_done_d = pix_wrap_s;
                end else begin
                    tile_done_d = 1'b0;
                end
            end else begin
                tile_done_d = 1'b0;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt_q   <= {PW{1'b0}};
            ch_cnt_q    <= {CW{1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {lenOfInput{1'b0}};
            tile_done_q <= 1'b0;
            sat_flag_q  <= 1'b0;
        end else begin
            pix_cnt_q   <= pix_cnt_d;
            ch_cnt_q    <= ch_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            tile_done_q <= tile_done_d;
            sat_flag_q  <= sat_flag_d;
        end
    end

    // Partial-sum buffer; contents are never read before being written, so no reset.
    always_ff @(posedge clk) begin
        if (buf_we_s) begin
            psum_buf_q[pix_cnt_q] <= in_result;
        end
    end

    // Feedback to the MAC: the first channel starts from zero.
    always_comb begin
        if (ch_cnt_q == {CW{1'b0}}) begin
            last_result = {lenOfOutput{1'b0}};
        end else begin
            last_result = psum_buf_q[pix_cnt_q];
        end
    end

    assign in_ready  = in_ready_s;
    assign pix_idx   = pix_cnt_q;
    assign ch_idx    = ch_cnt_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign tile_done = tile_done_q;
    assign sat_flag  = sat_flag_q;

endmodule

// File: tb/tb_conv_psum_accum.sv
// Self-checking bench for conv_psum_accum: directed scenarios plus random
// traffic, checked every cycle against a beat-indexed reference model.
module tb_conv_psum_accum;

    localparam int LI = 8;
    localparam int LO = 25;
    localparam int NP = 16;
    localparam int NC = 4;
    localparam int SH = 8;
    localparam int TILE = NP * NC;

    logic                 clk = 1'b0;
    logic                 rst, clr, in_valid, out_ready;
    logic                 in_ready, out_valid, tile_done, sat_flag;
    logic signed [LO-1:0] in_result, last_result;
    logic        [3:0]    pix_idx;
    logic        [1:0]    ch_idx;
    logic signed [LI-1:0] out_data;

    conv_psum_accum #(.lenOfInput(LI), .lenOfOutput(LO), .NUM_PIX(NP),
                      .NUM_CH(NC), .SHIFT(SH)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
        .in_ready(in_ready), .in_result(in_result), .last_result(last_result),
        .pix_idx(pix_idx), .ch_idx(ch_idx), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .tile_done(tile_done),
        .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: position in tile as a single beat number
    int m_beat;
    int m_store [NP];
    bit m_ov;
    int m_od;
    bit m_td;
    bit m_sat;
    int n_out;
    int n_td;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int m_last();
        if (m_beat / NP == 0) return 0;
        return m_store[m_beat % NP];
    endfunction

    function automatic bit m_rdy(input bit ordy);
        if (m_beat / NP < NC - 1) return 1'b1;
        return !m_ov || ordy;
    endfunction

    // ReLU, round-half-up, divide by 2^SH, clamp to int8 max
    function automatic int rq(input int x, output bit sat);
        int r;
        r = (x < 0) ? 0 : x;
        r = (r + (1 << (SH - 1))) / (1 << SH);
        sat = (r > 127);
        return sat ? 127 : r;
    endfunction

    task automatic cycle(input bit iv, input int x, input bit ordy,
                         input bit c, input bit r);
        logic signed [LO-1:0] xt;
        int xs;
        bit acc, s;
        xt = x[LO-1:0];
        xs = xt;
        in_valid = iv; in_result = xt; out_ready = ordy; clr = c; rst = r;
        #4;
        chk("in_ready", in_ready, m_rdy(ordy));
        chk("last_result", last_result, m_last());
        chk("pix_idx", pix_idx, m_beat % NP);
        chk("ch_idx", ch_idx, m_beat / NP);
        chk("out_valid", out_valid, m_ov);
        chk("out_data", out_data, m_od);
        chk("tile_done", tile_done, m_td);
        chk("sat_flag", sat_flag, m_sat);
        if (out_valid && ordy) n_out++;
        if (tile_done) n_td++;
        if (r || c) begin
            m_beat = 0; m_ov = 0; m_od = 0; m_td = 0; m_sat = 0;
        end else begin
            acc = iv && m_rdy(ordy);
            m_td = 0;
            if (m_ov && ordy) m_ov = 0;
            if (acc) begin
                if (m_beat / NP < NC - 1) begin
                    m_store[m_beat % NP] = xs;
                end else begin
                    m_ov = 1;
                    m_od = rq(xs, s);
                    if (s) m_sat = 1;
                end
                if (m_beat == TILE - 1) m_td = 1;
                m_beat = (m_beat + 1) % TILE;
            end
        end
        @(posedge clk); #1;
    endtask

    // MAC-like value: feedback plus a random product term
    function automatic int mac_val(input int span);
        return m_last() + $signed($urandom_range(0, 2 * span)) - span;
    endfunction

    task automatic run_tile(input int span, input int flush);
        for (int i = 0; i < TILE; i++) cycle(1'b1, mac_val(span), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < flush; i++) cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        in_valid = 1'b0; in_result = '0; out_ready = 1'b0; clr = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        m_beat = 0; m_ov = 0; m_od = 0; m_td = 0; m_sat = 0; n_out = 0; n_td = 0;
        for (int i = 0; i < NP; i++) m_store[i] = 0;
        cycle(1'b1, 12345, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);

        // Constant 1000 every beat: 16 outputs of 4, one tile_done
        n_out = 0; n_td = 0;
        for (int i = 0; i < TILE; i++) cycle(1'b1, 1000, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("c1000_outs", n_out, 16);
        chk("c1000_tile_done", n_td, 1);
        chk("c1000_value", out_data, 4);

        // Negative input and rounding boundary on the last channel
        for (int i = 0; i < TILE; i++) begin
            int x;
            x = mac_val(3000);
            if (i == 48) x = -5000;
            if (i == 49) x = 127;
            if (i == 50) x = 128;
            if (i == 51) x = 383;
            if (i == 52) x = 384;
            cycle(1'b1, x, 1'b1, 1'b0, 1'b0);
            if (i == 48) chk("neg_to_zero", out_data, 0);
            if (i == 49) chk("rnd_127", out_data, 0);
            if (i == 50) chk("rnd_128", out_data, 1);
            if (i == 52) chk("rnd_384", out_data, 2);
        end
        cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("no_sat_yet", sat_flag, 0);

        // Saturation is sticky across tiles until clr
        for (int i = 0; i < TILE; i++) begin
            int x;
            x = (i == 53) ? 40000 : mac_val(2000);
            cycle(1'b1, x, 1'b1, 1'b0, 1'b0);
            if (i == 53) chk("sat_value", out_data, 127);
        end
        chk("sat_set", sat_flag, 1);
        run_tile(500, 2);
        chk("sat_sticky", sat_flag, 1);
        cycle(1'b0, 0, 1'b1, 1'b1, 1'b0);
        chk("sat_clr", sat_flag, 0);

        // Backpressure on the last channel
        for (int i = 0; i < 48; i++) cycle(1'b1, mac_val(20000), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, mac_val(20000), 1'b0, 1'b0, 1'b0);
        chk("bp_stalled_pix", pix_idx, 1);
        chk("bp_in_ready", in_ready, 0);
        n_out = 0;
        for (int i = 0; i < 15; i++) cycle(1'b1, mac_val(20000), 1'b1, 1'b0, 1'b0);
        chk("bp_back_to_back", n_out, 15);
        chk("bp_wrapped_ch", ch_idx, 0);
        cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);

        // clr at ch2 pix7 together with a valid beat
        for (int i = 0; i < 39; i++) cycle(1'b1, mac_val(9000), 1'b1, 1'b0, 1'b0);
        n_td = 0;
        cycle(1'b1, 777, 1'b1, 1'b1, 1'b0);
        chk("clr_pix", pix_idx, 0);
        chk("clr_ch", ch_idx, 0);
        chk("clr_ov", out_valid, 0);
        run_tile(9000, 2);
        chk("clr_one_tile_done", n_td, 1);

        // rst mid-stream while output is pending
        for (int i = 0; i < 50; i++) cycle(1'b1, mac_val(30000), 1'b0, 1'b0, 1'b0);
        chk("pre_rst_ov", out_valid, 1);
        cycle(1'b1, 5, 1'b0, 1'b0, 1'b1);
        chk("rst_ov", out_valid, 0);
        chk("rst_od", out_data, 0);
        chk("rst_pix", pix_idx, 0);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            bit iv, ordy, c;
            int x;
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            c    = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 9) == 0)
                x = $signed($urandom_range(0, (1 << LO) - 1)) - (1 << (LO - 1));
            else
                x = mac_val(25000);
            cycle(iv, x, ordy, c, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_psum_accum.md
Name: conv_psum_accum

Overview:
- Downstream partner of the 4x4 convolution MAC stage; closes its accumulation loop across input channels.
- Keeps one partial sum per output pixel of a tile and drives it back to the MAC as last_result.
- Captures each returned MAC out_result.
- After the final channel, applies ReLU, rounding, right-shift and saturation, then emits an 8-bit activation through a valid/ready output register.

Parameters:
lenOfInput, 8, width of the output activation (matches MAC data width)
lenOfOutput, 25, width of partial sums / MAC result
NUM_PIX, 16, output pixels per tile (partial-sum buffer depth, >=2)
NUM_CH, 4, input channels accumulated per tile (>=1)
SHIFT, 8, requantisation right-shift (>=1)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
clr  input  1  synchronous tile restart: zero counters, drop pending output
in_valid  input  1  in_result valid from the MAC path
in_ready  output  1  block accepts in_result this cycle
in_result  input  lenOfOutput  MAC out_result (signed)
last_result  output  lenOfOutput  partial sum fed to MAC last_result (signed)
pix_idx  output  clog2(NUM_PIX)  pixel currently expected
ch_idx  output  clog2(NUM_CH)  channel currently expected
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data
out_data  output  lenOfInput  requantised activation (signed, never negative)
tile_done  output  1  one-cycle pulse: last pixel of last channel accepted
sat_flag  output  1  sticky: some output saturated since rst/clr

Behaviour:
- Reset (rst=1): pix_cnt=0, ch_cnt=0, out_valid=0, out_data=0, tile_done=0, sat_flag=0. Buffer contents are don't-care; never read before being written.
- clr: same as rst but has lower priority than rst.
- last_result is combinational from registered state:
  - 0 when ch_cnt==0;
  - otherwise psum_buf[pix_cnt].
- pix_idx=pix_cnt, ch_idx=ch_cnt.
- in_ready:
  - 1 when ch_cnt<NUM_CH-1;
  - on the last channel, in_ready = !out_valid || out_ready (output register empty or draining this cycle).
- Accept = in_valid && in_ready. On accept:
  - Non-last channel: psum_buf[pix_cnt] <= in_result.
  - Last channel: out_data/out_valid loaded next cycle (latency 1 from accept). psum_buf is not written.
  - Counter update:
    - pix_cnt increments and wraps NUM_PIX-1 -> 0.
    - On wrap, ch_cnt increments and wraps NUM_CH-1 -> 0.
    - tile_done pulses on the cycle after accepting pix NUM_PIX-1 of ch NUM_CH-1.
- No accept: counters, buffer and last_result hold.
- Requantisation (last-channel accept), applied in order:
  1. r = in_result<0 ? 0 : in_result
  2. r = r + 2^(SHIFT-1), computed at lenOfOutput+1 bits, no wrap
  3. r = r >> SHIFT
  4. If r > 2^(lenOfInput-1)-1: out_data = 2^(lenOfInput-1)-1 and sat_flag <= 1; else out_data = r.
- Output handshake:
  - out_valid && out_ready clears out_valid unless a new last-channel accept occurs in the same cycle; in that case out_valid stays 1 with the new data.
  - out_data must hold stable while out_valid && !out_ready.
- NUM_CH==1: every accept is last-channel; last_result is always 0.
- Simultaneous clr and accept: clr wins; the accept is discarded and no tile_done is produced.
- rst or clr mid-tile: all partial progress is lost; the next accepted beat is pix 0 ch 0.
- Partial sums are trusted to fit in lenOfOutput; no overflow check on intermediate channels.

Test Plan:
- NUM_CH=4, NUM_PIX=16, in_result=1000 every beat, out_ready=1 -> last_result sequence 0 (ch0), then 1000 per pixel for ch1-3. 16 outputs each equal to (1000+128)>>8 = 4. tile_done pulses once after beat 64.
- Last-channel in_result=-5000 -> out_data=0, sat_flag stays 0.
- Last-channel in_result=40000 -> out_data=127 and sat_flag=1. A following tile with small values keeps sat_flag=1 until clr.
- Backpressure on last channel: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 after the first output is loaded, out_data stable, no beat lost. Release gives back-to-back throughput of 1/cycle.
- clr asserted at ch=2 pix=7 together with in_valid -> beat dropped, ch_idx=0 pix_idx=0 next cycle, out_valid=0, no tile_done. Full tile after clr matches the golden model.
- rst asserted mid-stream with out_valid=1 -> all outputs at reset values the next cycle. Rounding boundary: in_result=127 -> 0, in_result=128 -> 1.
